// File: rtl/avalon_master_adapter.sv
// Avalon-MM initiator: valid/ready command stream in, pipelined Avalon reads and writes out,
// read data returned in issue order on a valid/ready response stream with credit-bounded reads.
module avalon_master_adapter #(
  parameter int unsigned BUSWIDTH     = 32,
  parameter int unsigned ADDRESSWIDTH = 8,
  parameter int unsigned MAX_PENDING  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [ADDRESSWIDTH-1:0]         cmd_address,
  input  logic [BUSWIDTH-1:0]             cmd_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [BUSWIDTH-1:0]             rsp_data,
  output logic                            avm_read,
  output logic                            avm_write,
  output logic [ADDRESSWIDTH-1:0]         avm_address,
  output logic [BUSWIDTH-1:0]             avm_writedata,
  input  logic                            avm_waitrequest,
  input  logic [BUSWIDTH-1:0]             avm_readdata,
  input  logic                            avm_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]    pending,
  output logic                            protocol_error
);
  localparam int unsigned PW = $clog2(MAX_PENDING) + 1;
  localparam int unsigned AW = $clog2(MAX_PENDING);

  logic                    req_active;
  logic                    req_write;
  logic [ADDRESSWIDTH-1:0] req_address;
  logic [BUSWIDTH-1:0]     req_data;

  logic [BUSWIDTH-1:0]     fifo_mem [MAX_PENDING];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [PW-1:0]           fifo_count;

  logic accept;
  logic read_accept;
  logic handshake;
  logic push;
  logic pop;
  logic has_credit;

  // Bus side is a direct view of the request register, so it holds through waitrequest.
  assign has_credit    = pending < PW'(MAX_PENDING);
  assign avm_write     = req_active & req_write;
  assign avm_read      = req_active & ~req_write & has_credit;
  assign avm_address   = req_address;
  assign avm_writedata = req_data;
  assign accept        = (avm_read | avm_write) & ~avm_waitrequest;
  assign read_accept   = avm_read & ~avm_waitrequest;
  assign cmd_ready     = ~req_active | accept;
  assign handshake     = cmd_valid & cmd_ready;

  // Returned data with no credit outstanding beyond the FIFO contents is a responder fault.
  assign rsp_valid = fifo_count != '0;
  assign pop       = rsp_valid & rsp_ready;
  assign push      = avm_readdatavalid & (pending != fifo_count);
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;

  // One-entry request register; reloads on the same cycle it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_active  <= 1'b0;
      req_write   <= 1'b0;
      req_address <= '0;
      req_data    <= '0;
    end else if (handshake) begin
      req_active  <= 1'b1;
      req_write   <= cmd_write;
      req_address <= cmd_address;
      req_data    <= cmd_data;
    end else if (accept) begin
      req_active  <= 1'b0;
    end
  end

  // Credits: reads on the bus side plus entries waiting in the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      case ({read_accept, pop})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + PW'(1);
        2'b01:   fifo_count <= fifo_count - PW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= avm_readdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if (avm_readdatavalid && (pending == fifo_count)) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_master_adapter.sv
// Self-checking bench for avalon_master_adapter: table-driven command vectors with a transfer and
// response scoreboard, plus directed sequences for waitrequest, credit, error and reset corners.
module tb_avalon_master_adapter;
  localparam int unsigned BW      = 32;
  localparam int unsigned AWID    = 8;
  localparam int unsigned MAXP    = 4;
  localparam int          TIMEOUT = 200;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AWID-1:0] cmd_address;
  logic [BW-1:0]   cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BW-1:0]   rsp_data;
  logic            avm_read;
  logic            avm_write;
  logic [AWID-1:0] avm_address;
  logic [BW-1:0]   avm_writedata;
  logic            avm_waitrequest;
  logic [BW-1:0]   avm_readdata;
  logic            avm_readdatavalid;
  logic [2:0]      pending;
  logic            protocol_error;

  avalon_master_adapter #(.BUSWIDTH(BW), .ADDRESSWIDTH(AWID), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .avm_read(avm_read), .avm_write(avm_write), .avm_address(avm_address),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .pending(pending), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            write;
    logic [AWID-1:0] addr;
    logic [BW-1:0]   data;
    logic [BW-1:0]   exp_rdata;
  } vec_t;

  typedef struct {
    logic            write;
    logic [AWID-1:0] addr;
    logic [BW-1:0]   data;
  } xfer_t;

  typedef struct {
    int            due;
    logic [BW-1:0] data;
  } ret_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  xfer_t         xfer_q[$];
  logic [BW-1:0] rsp_q[$];
  ret_t          rd_pipe[$];

  logic wr_random = 1'b0;
  logic wr_force  = 1'b0;
  logic rr_random = 1'b0;
  logic rr_force  = 1'b0;
  logic spurious  = 1'b0;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waitrequest and rsp_ready source, applied shortly after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    avm_waitrequest = wr_random ? ($urandom_range(0, 3) == 0) : wr_force;
    rsp_ready       = rr_random ? ($urandom_range(0, 1) == 1) : rr_force;
  end

  // Responder model (fixed 2-cycle read latency, data = 0xA0 + address) and scoreboard monitor.
  initial begin
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_pipe.size() > 0 && rd_pipe[0].due == cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rd_pipe[0].data;
        void'(rd_pipe.pop_front());
      end else begin
        avm_readdatavalid = spurious;
        avm_readdata      = 32'h5A5A_0BAD;
      end
      if (!reset && (avm_read || avm_write) && !avm_waitrequest) begin
        if (xfer_q.size() == 0) begin
          chk("xfer_unexpected", 32'(avm_address), 32'hFFFF_FFFF);
        end else begin
          xfer_t x;
          x = xfer_q.pop_front();
          chk("xfer_write", 32'(avm_write), 32'(x.write));
          chk("xfer_addr", 32'(avm_address), 32'(x.addr));
          if (x.write) chk("xfer_wdata", avm_writedata, x.data);
        end
        if (avm_read) rd_pipe.push_back('{cyc + 2, 32'h0000_00A0 + 32'(avm_address)});
      end
      if (!reset && rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_data, 32'hFFFF_FFFF);
        else chk("rsp_data", rsp_data, rsp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following the handshake.
  task automatic send_cmd(input logic w, input logic [AWID-1:0] a, input logic [BW-1:0] d,
                          input logic [BW-1:0] er, output int stalls);
    cmd_valid   = 1'b1;
    cmd_write   = w;
    cmd_address = a;
    cmd_data    = d;
    stalls      = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      stalls++;
      if (stalls > TIMEOUT) begin
        chk("cmd_timeout", 32'(stalls), 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (stalls <= TIMEOUT) begin
      xfer_q.push_back('{w, a, d});
      if (!w) rsp_q.push_back(er);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    wr_random = 1'b0; wr_force = 1'b0;
    rr_random = 1'b0; rr_force = 1'b1;
    n = 0;
    while ((xfer_q.size() != 0 || rsp_q.size() != 0 || rd_pipe.size() != 0 || rsp_valid)
           && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_xfer_left", 32'(xfer_q.size()), 32'd0);
    chk("drain_rsp_left", 32'(rsp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    xfer_q.delete();
    rsp_q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int st;
    int total;
    int base;
    tbl[0]  = '{1'b1, 8'h10, 32'h0123_4567, 32'h0};
    tbl[1]  = '{1'b0, 8'h05, 32'h0,         32'h0000_00A5};
    tbl[2]  = '{1'b0, 8'h06, 32'h0,         32'h0000_00A6};
    tbl[3]  = '{1'b1, 8'h07, 32'hCAFE_F00D, 32'h0};
    tbl[4]  = '{1'b0, 8'h40, 32'h0,         32'h0000_00E0};
    tbl[5]  = '{1'b0, 8'h41, 32'h0,         32'h0000_00E1};
    tbl[6]  = '{1'b0, 8'h42, 32'h0,         32'h0000_00E2};
    tbl[7]  = '{1'b0, 8'h43, 32'h0,         32'h0000_00E3};
    tbl[8]  = '{1'b0, 8'h44, 32'h0,         32'h0000_00E4};
    tbl[9]  = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 32'h0};
    tbl[10] = '{1'b0, 8'hFF, 32'h0,         32'h0000_019F};
    tbl[11] = '{1'b0, 8'h00, 32'h0,         32'h0000_00A0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_data = '0;
    avm_waitrequest = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_perr", 32'(protocol_error), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1; @(posedge clk); #1;
    reset = 1'b0;

    // Single write with zero waitrequest: one bus cycle, then idle.
    send_cmd(1'b1, 8'h12, 32'hDEAD_BEEF, 32'h0, st);
    @(negedge clk);
    chk("wr1_avm_write", 32'(avm_write), 32'd1);
    chk("wr1_addr", 32'(avm_address), 32'h12);
    chk("wr1_data", avm_writedata, 32'hDEAD_BEEF);
    chk("wr1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("wr1_write_drop", 32'(avm_write), 32'd0);
    @(posedge clk); #1;

    // Write held by 3 cycles of waitrequest.
    wr_force = 1'b1;
    send_cmd(1'b1, 8'h34, 32'h1357_9BDF, 32'h0, st);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wws_avm_write", 32'(avm_write), 32'd1);
      chk("wws_addr", 32'(avm_address), 32'h34);
      chk("wws_data", avm_writedata, 32'h1357_9BDF);
      chk("wws_cmd_ready", 32'(cmd_ready), (i < 3) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      if (i == 2) wr_force = 1'b0;
    end
    @(negedge clk);
    chk("wws_write_drop", 32'(avm_write), 32'd0);
    @(posedge clk); #1;
    drain();

    // Credit limit: four reads fill the credits, fifth waits for the first pop.
    rr_force = 1'b0;
    for (int i = 0; i < 4; i++)
      send_cmd(1'b0, AWID'(i), 32'h0, 32'h0000_00A0 + 32'(i), st);
    send_cmd(1'b0, 8'h04, 32'h0, 32'h0000_00A4, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cred_read_low", 32'(avm_read), 32'd0);
      chk("cred_pending", 32'(pending), 32'd4);
    end
    @(posedge clk); #1;
    rr_force = 1'b1;
    @(negedge clk);
    chk("cred_pop_cycle_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("cred_pop_cycle_read", 32'(avm_read), 32'd0);
    @(negedge clk);
    chk("cred_after_pop_read", 32'(avm_read), 32'd1);
    @(posedge clk); #1;
    drain();

    // Interleaved write/read/write streaming with no stalls, exactly one response.
    base = rsp_cnt;
    total = 0;
    send_cmd(1'b1, 8'h20, 32'h1111_1111, 32'h0, st); total += st;
    send_cmd(1'b0, 8'h21, 32'h0, 32'h0000_00C1, st); total += st;
    send_cmd(1'b1, 8'h22, 32'h2222_2222, 32'h0, st); total += st;
    chk("ilv_stalls", 32'(total), 32'd0);
    drain();
    chk("ilv_rsp_count", 32'(rsp_cnt - base), 32'd1);

    // Table vectors: first under random waitrequest/rsp_ready, then streaming zero-wait.
    for (int pass = 0; pass < 2; pass++) begin
      wr_random = (pass == 0); rr_random = (pass == 0);
      wr_force = 1'b0; rr_force = 1'b1;
      for (int i = 0; i < 12; i++)
        send_cmd(tbl[i].write, tbl[i].addr, tbl[i].data, tbl[i].exp_rdata, st);
      drain();
      chk("tbl_perr", 32'(protocol_error), 32'd0);
      chk("tbl_pending_idle", 32'(pending), 32'd0);
    end

    // Spurious readdatavalid: sticky error, FIFO untouched, cleared only by reset.
    @(posedge clk); #1;
    spurious = 1'b1;
    @(posedge clk); #1;
    spurious = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("perr_set", 32'(protocol_error), 32'd1);
    chk("perr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("perr_pending", 32'(pending), 32'd0);
    repeat (5) @(negedge clk);
    chk("perr_sticky", 32'(protocol_error), 32'd1);
    @(posedge clk); #1;
    do_reset();
    chk("perr_cleared", 32'(protocol_error), 32'd0);

    // Reset with one response queued and two reads in flight.
    rr_force = 1'b0;
    send_cmd(1'b0, 8'h30, 32'h0, 32'h0000_00D0, st);
    st = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      st++;
      if (st > 20) begin
        chk("rr_wait_rsp", 32'(rsp_valid), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    send_cmd(1'b0, 8'h31, 32'h0, 32'h0000_00D1, st);
    send_cmd(1'b0, 8'h32, 32'h0, 32'h0000_00D2, st);
    @(posedge clk); #1;
    chk("rr_pre_pending", 32'(pending), 32'd3);
    reset = 1'b1;
    xfer_q.delete();
    rsp_q.delete();
    #1;
    chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rr_pending", 32'(pending), 32'd0);
    chk("rr_avm_read", 32'(avm_read), 32'd0);
    chk("rr_avm_write", 32'(avm_write), 32'd0);
    chk("rr_addr", 32'(avm_address), 32'd0);
    chk("rr_wdata", avm_writedata, 32'd0);
    chk("rr_rsp_data", rsp_data, 32'd0);
    chk("rr_perr", 32'(protocol_error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rr_cmd_ready_after", 32'(cmd_ready), 32'd1);
    chk("rr_pending_after", 32'(pending), 32'd0);
    repeat (4) @(negedge clk);
    chk("rr_late_rdv_perr", 32'(protocol_error), 32'd1);
    chk("rr_late_rdv_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rr_late_rdv_pending", 32'(pending), 32'd0);
    @(posedge clk); #1;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_master_adapter.md
# avalon_master_adapter

Avalon-MM initiator that turns a simple valid/ready command stream into pipelined Avalon-MM read/write transfers and returns read data on a valid/ready response stream. It is the initiator counterpart to the team's register-side Avalon responder. It honours waitrequest and readdatavalid, and bounds outstanding reads so that no returning read data is ever dropped.

## Interface
Parameters:
- BUSWIDTH, 32, data width of command, response and Avalon data buses
- ADDRESSWIDTH, 8, word address width
- MAX_PENDING, 4, max reads issued but not yet popped from rsp; also response FIFO depth; power of 2, >= 2

Ports (one clock domain; reset asynchronous, active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDRESSWIDTH  target address
- cmd_data  in  BUSWIDTH  write data (ignored for reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer pops when rsp_valid & rsp_ready
- rsp_data  out  BUSWIDTH  read data, in issue order
- avm_read  out  1  Avalon read request
- avm_write  out  1  Avalon write request
- avm_address  out  ADDRESSWIDTH  Avalon address
- avm_writedata  out  BUSWIDTH  Avalon write data
- avm_waitrequest  in  1  responder stall; request holds while high
- avm_readdata  in  BUSWIDTH  returned read data
- avm_readdatavalid  in  1  avm_readdata valid this cycle
- pending  out  $clog2(MAX_PENDING)+1  credits in use (reads in flight + FIFO occupancy)
- protocol_error  out  1  sticky: readdatavalid arrived with no read in flight

## Operation
- One-entry request register (req_active, req_write, req_address, req_data) loaded on command handshake.
- accept = (avm_read | avm_write) & !avm_waitrequest.
- cmd_ready = !req_active | accept. This is a combinational path from avm_waitrequest. It allows one transfer per cycle.
- avm_write = req_active & req_write.
- avm_read = req_active & !req_write & (pending < MAX_PENDING). A read with no credit stalls in the register with avm_read low.
- avm_address/avm_writedata = request register contents. They hold stable while waitrequest is high.
- On accept without a new handshake, req_active clears. On a simultaneous accept and handshake, the register reloads.
- Credit counter pending: +1 on accepted read; −1 on rsp pop; both in the same cycle leave it unchanged. It never exceeds MAX_PENDING.
- Response FIFO, depth MAX_PENDING: pushes avm_readdata on avm_readdatavalid. The credit rule guarantees it never overflows.
- rsp_data = FIFO head when rsp_valid, else 0.
- protocol_error sets when avm_readdatavalid & (pending == FIFO count). It stays set until reset; the data is discarded.
- Writes consume no credit and never generate a response.
- Transfers issue strictly in command order. A read stalled for credit also blocks any later write.

## Timing
- Reset (asynchronous, any cycle): req_active, avm_read, avm_write, rsp_valid, protocol_error = 0; avm_address, avm_writedata, rsp_data, pending = 0; FIFO emptied.
- cmd_ready = 1 immediately after reset. Reads in flight at reset are forgotten; their later readdatavalid raises protocol_error.
- Command latency: a handshake at edge N drives avm_* from cycle N+1.
- Zero-wait responder: back-to-back commands produce one Avalon transfer per cycle.
- Read return: readdatavalid in cycle M gives rsp_valid high from cycle M+1 (registered FIFO, no fall-through).
- Full boundary: with pending == MAX_PENDING, avm_read stays low. A pop in cycle K lets avm_read assert in cycle K+1.
- Empty boundary: a pop and a push in the same cycle on a 1-entry FIFO keep rsp_valid high and present the new data.

## Test plan
- Single write, cmd_address=0x12 and cmd_data=0xDEADBEEF, waitrequest low -> avm_write high for exactly 1 cycle, one cycle after the handshake, with address 0x12 and data 0xDEADBEEF; no rsp_valid.
- Write with waitrequest high for 3 cycles -> avm_write, avm_address and avm_writedata held for 4 cycles; cmd_ready low for 3 cycles.
- 4 reads to 0x00–0x03 with rsp_ready=0 and the responder returning 0xA0–0xA3 after 2 cycles -> pending reaches 4; a 5th read holds avm_read low. Raising rsp_ready -> pops 0xA0..0xA3 in order, then the 5th read issues the cycle after the first pop.
- Interleaved write/read/write with streaming commands and zero waitrequest -> three consecutive Avalon transfer cycles in command order; exactly one response.
- avm_readdatavalid pulsed with pending=0 -> protocol_error high and held; FIFO unchanged; cleared only by reset.
- Reset asserted with 2 reads in flight and 1 response queued -> all outputs at reset values within the same cycle; cmd_ready=1 after release; pending=0.
